// File: rtl/disp_pkg.sv
// Shared definitions for the display scanning blocks: state encoding,
// nibble width and an elaboration-time ceil(log2) helper.
package disp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running scan-rate divider: TICK is high while the count sits at
// PRESCALE-1; CLR holds the count at zero.
module disp_prescaler
  import disp_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int PW = (clog2(PRESCALE) > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_r;

  assign TICK = (count_r == LAST);

  // count 0..PRESCALE-1, wrap on tick, park at zero while cleared
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_r <= '0;
    end else if (CLR || TICK) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scanner.sv
// N-digit time-multiplexed 7-segment scanner with frame snapshot, blanking gap
// and enable handshake. Optional leading-zero blanking: DISP_LEADING_ZERO_BLANK_EN.
module disp_scanner
  import disp_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int PRESCALE  = 50000,
  parameter int GAP_TICKS = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic [NIBBLE_W*DIGITS-1:0] VALUE,
  input  logic [DIGITS-1:0]          DOT,
  output logic [NIBBLE_W-1:0]        DISP,
  output logic                       DP,
  output logic [DIGITS-1:0]          DIG_SEL,
  output logic                       FRAME
);

  localparam int IW = (clog2(DIGITS) > 1) ? clog2(DIGITS) : 1;
  localparam int GW = (clog2(GAP_TICKS + 1) > 1) ? clog2(GAP_TICKS + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;
  localparam logic [DIGITS-1:0] ONE_HOT = DIGITS'(1);

  state_e                     state_r, state_s;
  logic [IW-1:0]              idx_r, idx_s, adv_idx_s;
  logic [GW-1:0]              gap_r, gap_s;
  logic [NIBBLE_W*DIGITS-1:0] val_r, val_s;
  logic [DIGITS-1:0]          dot_r, dot_s;
  logic                       frame_s, wrap_s, tick_s, clr_s;
  logic [DIGITS-1:0]          keep_s, dig_sel_s;
  logic [NIBBLE_W-1:0]        disp_s;
  logic                       dp_s;

  assign clr_s     = (state_r == IDLE) || !EN;
  assign wrap_s    = (idx_r == IDX_LAST);
  assign adv_idx_s = wrap_s ? '0 : idx_r + 1'b1;

  disp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (clr_s),
    .TICK  (tick_s)
  );

  // next-state: EN has priority over a coincident tick
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    gap_s   = gap_r;
    val_s   = val_r;
    dot_s   = dot_r;
    frame_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (EN) begin
          state_s = ON;
          idx_s   = '0;
          val_s   = VALUE;
          dot_s   = DOT;
          frame_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (!EN) begin
          state_s = IDLE;
          idx_s   = '0;
          gap_s   = '0;
        end else if (tick_s && (GAP_TICKS > 0)) begin
          state_s = GAP;
          gap_s   = '0;
        end else if (tick_s) begin
          state_s = ON;
          idx_s   = adv_idx_s;
          if (wrap_s) begin
            val_s   = VALUE;
            dot_s   = DOT;
            frame_s = 1'b1;
          end else begin
            frame_s = 1'b0;
          end
        end else begin
          state_s = ON;
        end
      end
      GAP: begin
        if (!EN) begin
          state_s = IDLE;
          idx_s   = '0;
          gap_s   = '0;
        end else if (tick_s && (gap_r == GAP_LAST)) begin
          state_s = ON;
          idx_s   = adv_idx_s;
          if (wrap_s) begin
            val_s   = VALUE;
            dot_s   = DOT;
            frame_s = 1'b1;
          end else begin
            frame_s = 1'b0;
          end
        end else if (tick_s) begin
          gap_s = gap_r + 1'b1;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
        gap_s   = '0;
      end
    endcase
  end

`ifdef DISP_LEADING_ZERO_BLANK_EN
  // keep a digit if it or any higher digit is nonzero or dotted; digit 0 always
  always_comb begin
    logic seen;
    seen   = 1'b0;
    keep_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen      = seen | (val_s[NIBBLE_W*i +: NIBBLE_W] != 4'h0) | dot_s[i];
      keep_s[i] = seen | (i == 0);
    end
  end
`else
  assign keep_s = '1;
`endif

  // output values for the cycle being entered, computed from next state
  always_comb begin
    dig_sel_s = '0;
    disp_s    = 4'h0;
    dp_s      = 1'b0;
    if ((state_s == ON) && keep_s[idx_s]) begin
      dig_sel_s = ONE_HOT << idx_s;
      disp_s    = val_s[NIBBLE_W*idx_s +: NIBBLE_W];
      dp_s      = dot_s[idx_s];
    end else begin
      dig_sel_s = '0;
      disp_s    = 4'h0;
      dp_s      = 1'b0;
    end
  end

  // state, snapshot and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      idx_r   <= '0;
      gap_r   <= '0;
      val_r   <= '0;
      dot_r   <= '0;
      DIG_SEL <= '0;
      DISP    <= 4'h0;
      DP      <= 1'b0;
      FRAME   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      gap_r   <= gap_s;
      val_r   <= val_s;
      dot_r   <= dot_s;
      DIG_SEL <= dig_sel_s;
      DISP    <= disp_s;
      DP      <= dp_s;
      FRAME   <= frame_s;
    end
  end

endmodule

// File: tb/tb_disp_scanner.sv
// Directed bench for disp_scanner: 4-digit/prescale-4/gap-1 instance plus a
// 2-digit/prescale-3/no-gap instance sharing the clock and reset.
module tb_disp_scanner;

  logic        clk;
  logic        rst_n;
  logic        en_a, en_b;
  logic [15:0] value_a;
  logic [3:0]  dot_a;
  logic [3:0]  disp_a;
  logic        dp_a, frame_a;
  logic [3:0]  sel_a;
  logic [7:0]  value_b;
  logic [1:0]  dot_b;
  logic [3:0]  disp_b;
  logic        dp_b, frame_b;
  logic [1:0]  sel_b;

  int total = 0;
  int bad   = 0;

`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] VIS_NODOT = 4'b0011;
  localparam logic [3:0] VIS_DOT2  = 4'b0111;
  localparam logic [3:0] VIS_ZERO  = 4'b0001;
`else
  localparam logic [3:0] VIS_NODOT = 4'b1111;
  localparam logic [3:0] VIS_DOT2  = 4'b1111;
  localparam logic [3:0] VIS_ZERO  = 4'b1111;
`endif

  disp_scanner #(.DIGITS(4), .PRESCALE(4), .GAP_TICKS(1)) u_a (
    .CLK(clk), .RST_N(rst_n), .EN(en_a), .VALUE(value_a), .DOT(dot_a),
    .DISP(disp_a), .DP(dp_a), .DIG_SEL(sel_a), .FRAME(frame_a)
  );

  disp_scanner #(.DIGITS(2), .PRESCALE(3), .GAP_TICKS(0)) u_b (
    .CLK(clk), .RST_N(rst_n), .EN(en_b), .VALUE(value_b), .DOT(dot_b),
    .DISP(disp_b), .DP(dp_b), .DIG_SEL(sel_b), .FRAME(frame_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  // one frame of instance A: {FRAME,DP,DISP,DIG_SEL}; optional mid-frame VALUE change
  task automatic run_frame(input string tag, input logic [15:0] ev, input logic [3:0] ed,
                           input logic [3:0] vis, input int ncyc, input int chg_d,
                           input logic [15:0] newv);
    for (int k = 0; k < ncyc; k++) begin
      int d, c;
      logic [9:0] e;
      d = k / 8;
      c = k % 8;
      cyc();
      if (c < 4 && vis[d])
        e = {(d == 0 && c == 0), ed[d], ev[4*d +: 4], 4'(1 << d)};
      else
        e = {(d == 0 && c == 0), 1'b0, 4'h0, 4'h0};
      chk(tag, k, {6'd0, frame_a, dp_a, disp_a, sel_a}, {6'd0, e});
      if (d == chg_d && c == 1) value_a = newv;
    end
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    value_a = 16'h0; dot_a = 4'h0; value_b = 8'h5A; dot_b = 2'b00;
    #1;
    chk("reset_a", 0, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    chk("reset_b", 0, {8'd0, frame_b, dp_b, disp_b, sel_b}, 16'h0);
    repeat (3) cyc();
    rst_n = 1'b1;

    for (int k = 0; k < 50; k++) begin
      cyc();
      chk("idle_a", k, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    end

    value_a = 16'h1234; dot_a = 4'b0001; en_a = 1'b1;
    run_frame("f1234", 16'h1234, 4'b0001, 4'hF, 32, -1, 16'h0);
    run_frame("midchg", 16'h1234, 4'b0001, 4'hF, 32, 1, 16'hABCD);
    run_frame("fABCD", 16'hABCD, 4'b0001, 4'hF, 32, -1, 16'h0);

    // drop EN in digit 2's ON slot
    run_frame("pre_drop", 16'hABCD, 4'b0001, 4'hF, 17, -1, 16'h0);
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("dropped", k, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    end
    en_a = 1'b1;
    run_frame("reen", 16'hABCD, 4'b0001, 4'hF, 32, -1, 16'h0);

    // EN drop on the same edge as the gap-ending tick
    run_frame("pre_tick", 16'hABCD, 4'b0001, 4'hF, 8, -1, 16'h0);
    en_a = 1'b0;
    cyc();
    chk("en_vs_tick", 0, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    en_a = 1'b1;
    run_frame("reen2", 16'hABCD, 4'b0001, 4'hF, 32, -1, 16'h0);

    value_a = 16'h0034; dot_a = 4'b0000;
    run_frame("lz_nodot", 16'h0034, 4'b0000, VIS_NODOT, 32, -1, 16'h0);
    dot_a = 4'b0100;
    run_frame("lz_dot2", 16'h0034, 4'b0100, VIS_DOT2, 32, -1, 16'h0);
    value_a = 16'h0000; dot_a = 4'b0000;
    run_frame("lz_zero", 16'h0000, 4'b0000, VIS_ZERO, 32, -1, 16'h0);

    // asynchronous reset mid-slot
    value_a = 16'h1234; dot_a = 4'b0001;
    run_frame("pre_rst", 16'h1234, 4'b0001, 4'hF, 3, -1, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 0, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    en_a = 1'b0;
    cyc();
    rst_n = 1'b1;

    // two digits, no gap: 01/A then 10/5, three cycles each
    en_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int d, c;
      logic [7:0] e;
      d = (k / 3) % 2;
      c = k % 3;
      cyc();
      e = {(d == 0 && c == 0), 1'b0, (d == 1) ? 4'h5 : 4'hA, (d == 1) ? 2'b10 : 2'b01};
      chk("two_dig", k, {8'd0, frame_b, dp_b, disp_b, sel_b}, {8'd0, e});
      chk("a_dark", k, {6'd0, frame_a, dp_a, disp_a, sel_a}, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scanner.md
Name: disp_scanner

Overview:
- Parametrised time-multiplexed display scanner for N-digit 7-segment banks. It is the successor to the fixed two-digit nibble selector.
- Generates its own scan rate from CLK with an internal prescaler, cycles one-hot digit enables, and routes the matching nibble and decimal point to the shared decoder.
- Captures a snapshot of VALUE/DOT at each frame start, so a digit never shows a half-updated value.
- Adds an inter-digit blanking gap (anti-ghosting) and an enable handshake.

Parameters:
- DIGITS, 2, number of digits scanned (>=1)
- PRESCALE, 50000, CLK cycles per scan tick (>=1; 1 = tick every cycle)
- GAP_TICKS, 1, blank ticks inserted after each digit slot (0 = no gap)

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  scan enable; 0 = display dark
- VALUE  input  4*DIGITS  packed nibbles; digit i = VALUE[4i+3:4i]
- DOT  input  DIGITS  decimal point per digit
- DISP  output  4  nibble for the currently selected digit (to segment decoder)
- DP  output  1  decimal point of the selected digit
- DIG_SEL  output  DIGITS  one-hot digit enable, active high
- FRAME  output  1  one-cycle pulse at each frame start (digit 0 slot begins)

Behaviour:
- Reset (RST_N=0, async): state IDLE, DIG_SEL=0, DISP=0, DP=0, FRAME=0, idx=0, prescaler=0, shadow regs=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Prescaler: counts 0..PRESCALE-1. tick=1 in the cycle the count equals PRESCALE-1, then wraps to 0. The prescaler is held at 0 in IDLE.
- State IDLE:
  - DIG_SEL=0, DISP=0, DP=0.
  - When EN=1 at a clock edge: next state ON, idx=0, shadow<=VALUE/DOT, FRAME=1 for that one cycle.
- State ON:
  - DIG_SEL=1<<idx, DISP=shadow nibble[idx], DP=shadow DOT[idx].
  - On tick: go to GAP if GAP_TICKS>0 (gap count=0); otherwise advance the digit.
- State GAP:
  - DIG_SEL=0, DISP=0, DP=0.
  - Count ticks; on the GAP_TICKS-th tick, advance the digit.
- Advance digit: idx<=idx+1 and state ON. If idx=DIGITS-1, idx wraps to 0 and the frame restarts: shadow<=VALUE/DOT, FRAME=1.
- Slot timing:
  - Each digit slot = PRESCALE cycles ON + GAP_TICKS*PRESCALE cycles dark.
  - Frame period = DIGITS*PRESCALE*(1+GAP_TICKS) cycles.
- VALUE/DOT changes mid-frame have no effect until the next frame start.
- EN=0 in ON or GAP: the next edge enters IDLE, blanks all outputs, and clears idx and the prescaler. A re-enable always restarts at digit 0 with a FRAME pulse.
- EN toggling in the same cycle as a tick: EN takes priority, so the state goes to IDLE.
- DIGITS=1: idx stays 0. The snapshot and FRAME occur every slot.
- Reset mid-frame: immediate return to the reset values; no partial slot resumes.
- Width rules:
  - idx width = max(1, clog2(DIGITS)).
  - prescaler width = max(1, clog2(PRESCALE)).
  - gap counter width = max(1, clog2(GAP_TICKS+1)).

Optional Feature:
- Macro DISP_LEADING_ZERO_BLANK_EN.
- Defined: in each frame (evaluated on the shadow regs), every digit above the most significant nonzero nibble is blanked during its ON slot (DIG_SEL=0, DISP=0, DP=0).
  - Slot timing and FRAME are unchanged.
  - Digit 0 is never blanked.
  - A digit whose DOT bit is set is never blanked, and neither is any digit below it.
- Undefined: all digits are always shown; no leading-zero logic is synthesised.

Decomposition:
- Shared package/header disp_pkg:
  - state encodings IDLE=2'd0, ON=2'd1, GAP=2'd2
  - clog2 function
  - NIBBLE_W=4 constant
- One natural sub-module: disp_prescaler (parameter PRESCALE; ports CLK, RST_N, CLR, TICK), reusable by other display blocks.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, GAP_TICKS=1 unless stated.
1. Reset, EN=0: all outputs 0. Release reset with EN held 0 for 50 cycles -> outputs stay 0, FRAME never pulses. Assert RST_N low mid-scan -> outputs 0 asynchronously.
2. VALUE=16'h1234, DOT=4'b0001, EN=1 -> the scan proceeds as follows, and FRAME repeats every 32 cycles:
   - FRAME pulses once.
   - DIG_SEL=0001, DISP=4, DP=1 for 4 cycles.
   - DIG_SEL=0000 for 4 cycles.
   - DIG_SEL=0010, DISP=3, DP=0.
   - Then DISP=2, then DISP=1.
3. Change VALUE to 16'hABCD during digit 1's ON slot -> digits 1..3 still show 3,2,1. After the next FRAME the display shows D,C,B,A.
4. Drop EN during digit 2's ON slot -> next cycle DIG_SEL=0, DISP=0. Re-raise EN 10 cycles later -> FRAME pulse, digit 0 slot restarts with a full 4 cycles.
5. DIGITS=2, PRESCALE=3, GAP_TICKS=0, VALUE=8'h5A -> DIG_SEL alternates 01/10 every 3 cycles with DISP=A/5, no dark cycles, FRAME every 6 cycles.
6. With DISP_LEADING_ZERO_BLANK_EN, VALUE=16'h0034:
   - DOT=0 -> digit 2 and 3 slots dark, digits 0 and 1 show 4 and 3.
   - DOT=4'b0100 -> digit 2 shows 0 with DP=1, digit 3 dark.
   - VALUE=0 -> only digit 0 shows 0.
